// File: rtl/lab2_proc_fetch_buf_if.sv
// Fetch-buffer bus: the F-stage fetch request, the imem request/response ports and the D-stage stream.
// The buffer side uses "master"; the ctrl/imem/D environment uses "slave".
interface lab2_proc_fetch_buf_if;
  logic        fetch_val;
  logic [31:0] fetch_addr;
  logic        fetch_rdy;
  logic        squash;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic        imemresp_rdy;
  logic [31:0] imemresp_data;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [3:0]  drop_count;

  modport master (
    input  fetch_val, fetch_addr, squash, imemreq_rdy, imemresp_val, imemresp_data, inst_rdy,
    output fetch_rdy, imemreq_val, imemreq_addr, imemresp_rdy, inst_val, inst_data, inst_pc,
           drop_count
  );

  modport slave (
    output fetch_val, fetch_addr, squash, imemreq_rdy, imemresp_val, imemresp_data, inst_rdy,
    input  fetch_rdy, imemreq_val, imemreq_addr, imemresp_rdy, inst_val, inst_data, inst_pc,
           drop_count
  );
endinterface

// File: rtl/lab2_proc_fetch_buf.sv
// Credit-tracked fetch buffer: issues imem requests tagged with their PC, drops responses
// belonging to squashed fetches, and queues surviving instructions for D.
//
// Handshakes: a transfer happens on a cycle where both val and rdy are high at the clock
// edge; val never depends on rdy, and rdy may depend on val.
module lab2_proc_fetch_buf #(
  parameter int p_depth = 2
) (
  input logic                   clk,
  input logic                   reset,
  lab2_proc_fetch_buf_if.master bus
);

  localparam int         AW       = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int         NE       = 1 << AW;
  localparam logic [4:0] LP_DEPTH = 5'(p_depth);

  typedef logic [AW-1:0] ptr_t;

  // PC queue: one entry per live (non-squashed) request in flight
  logic [31:0] r_pcq [NE];
  ptr_t        r_pcq_head;
  ptr_t        r_pcq_tail;
  logic [3:0]  r_live;

  logic [31:0] r_iq_pc   [NE];
  logic [31:0] r_iq_data [NE];
  ptr_t        r_iq_head;
  ptr_t        r_iq_tail;
  logic [3:0]  r_buf_cnt;

  logic [3:0]  r_drop_cnt;

  logic [4:0]  w_total;
  logic        w_credit_ok;
  logic        w_req_fire;
  logic        w_resp_fire;
  logic        w_resp_drop;
  logic        w_resp_keep;
  logic        w_inst_fire;

  function automatic ptr_t f_next(input ptr_t p);
    return (p == ptr_t'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_total     = {1'b0, r_live} + {1'b0, r_drop_cnt} + {1'b0, r_buf_cnt};
  assign w_credit_ok = (w_total < LP_DEPTH);

  assign bus.imemreq_val  = bus.fetch_val && w_credit_ok;
  assign bus.imemreq_addr = bus.fetch_addr;
  assign bus.fetch_rdy    = bus.imemreq_rdy && w_credit_ok;
  // Credits reserve queue space for every response, so responses are never back-pressured
  assign bus.imemresp_rdy = 1'b1;

  assign w_req_fire  = bus.fetch_val && bus.imemreq_rdy && w_credit_ok;
  assign w_resp_fire = bus.imemresp_val;
  assign w_resp_drop = w_resp_fire && (r_drop_cnt != 4'd0);
  assign w_resp_keep = w_resp_fire && (r_drop_cnt == 4'd0);

  assign bus.inst_val   = (r_buf_cnt != 4'd0) && !bus.squash;
  assign bus.inst_data  = r_iq_data[r_iq_head];
  assign bus.inst_pc    = r_iq_pc[r_iq_head];
  assign bus.drop_count = r_drop_cnt;
  assign w_inst_fire    = bus.inst_val && bus.inst_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) r_pcq[i] <= '0;
      r_pcq_head <= '0;
      r_pcq_tail <= '0;
      r_live     <= 4'd0;
    end else if (bus.squash) begin
      // A request firing alongside squash is the redirect target and survives alone
      r_pcq_head <= '0;
      if (w_req_fire) begin
        r_pcq[0]   <= bus.fetch_addr;
        r_pcq_tail <= f_next('0);
        r_live     <= 4'd1;
      end else begin
        r_pcq_tail <= '0;
        r_live     <= 4'd0;
      end
    end else begin
      if (w_req_fire) begin
        r_pcq[r_pcq_tail] <= bus.fetch_addr;
        r_pcq_tail        <= f_next(r_pcq_tail);
      end
      if (w_resp_keep) r_pcq_head <= f_next(r_pcq_head);
      r_live <= r_live + {3'b0, w_req_fire} - {3'b0, w_resp_keep};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) begin
        r_iq_pc[i]   <= '0;
        r_iq_data[i] <= '0;
      end
      r_iq_head <= '0;
      r_iq_tail <= '0;
      r_buf_cnt <= 4'd0;
    end else if (bus.squash) begin
      r_iq_head <= '0;
      r_iq_tail <= '0;
      r_buf_cnt <= 4'd0;
    end else begin
      if (w_resp_keep) begin
        r_iq_pc[r_iq_tail]   <= r_pcq[r_pcq_head];
        r_iq_data[r_iq_tail] <= bus.imemresp_data;
        r_iq_tail            <= f_next(r_iq_tail);
      end
      if (w_inst_fire) r_iq_head <= f_next(r_iq_head);
      r_buf_cnt <= r_buf_cnt + {3'b0, w_resp_keep} - {3'b0, w_inst_fire};
    end
  end

  // Responses return in order, so squashed requests are always the oldest outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= 4'd0;
    end else if (bus.squash) begin
      r_drop_cnt <= r_drop_cnt + r_live - {3'b0, w_resp_fire};
    end else if (w_resp_drop) begin
      r_drop_cnt <= r_drop_cnt - 4'd1;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(w_resp_fire && (({1'b0, r_live} + {1'b0, r_drop_cnt}) == 5'd0)))
        else $error("imem response with nothing outstanding");
      assert ({1'b0, r_drop_cnt} <= LP_DEPTH)
        else $error("drop_count above p_depth");
    end
  end

endmodule

// File: tb/tb_lab2_proc_fetch_buf.sv
// Directed bench for lab2_proc_fetch_buf (p_depth=2): a latency-1 imem model, an expected-PC
// scoreboard for instructions reaching D, and hand-computed checks of credits and squash.
module tb_lab2_proc_fetch_buf;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] exp_q [$];
  logic [31:0] mem_q [$];

  lab2_proc_fetch_buf_if bus ();

  lab2_proc_fetch_buf #(.p_depth(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drivers: drive() sets one cycle's inputs at the negedge, commit() records fires and advances
  task automatic drive(input logic fv, input logic [31:0] fa, input logic sq,
                       input logic irdy, input logic resp_en);
    bus.fetch_val  = fv;
    bus.fetch_addr = fa;
    bus.squash     = sq;
    bus.inst_rdy   = irdy;
    if (resp_en && mem_q.size() > 0) begin
      bus.imemresp_val  = 1'b1;
      bus.imemresp_data = word_of(mem_q[0]);
    end else begin
      bus.imemresp_val  = 1'b0;
      bus.imemresp_data = 32'h0;
    end
    #1;
  endtask

  task automatic commit();
    logic [31:0] tmp;
    if (bus.inst_val && bus.inst_rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("inst_unexpected", bus.inst_pc, 32'hFFFF_FFFF);
      end else begin
        tmp = exp_q.pop_front();
        check_eq("inst_pc", bus.inst_pc, tmp);
        check_eq("inst_data", bus.inst_data, word_of(tmp));
      end
    end
    if (bus.imemreq_val && bus.imemreq_rdy) mem_q.push_back(bus.imemreq_addr);
    if (bus.imemresp_val && bus.imemresp_rdy) tmp = mem_q.pop_front();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    check_eq({tag, "_inst_val"}, 32'(bus.inst_val), 32'd0);
    check_eq({tag, "_drop"}, 32'(bus.drop_count), 32'd0);
    check_eq({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
    check_eq({tag, "_inst_data"}, bus.inst_data, 32'd0);
    check_eq({tag, "_fetch_rdy"}, 32'(bus.fetch_rdy), 32'd1);
    mem_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.fetch_val     = 1'b0;
    bus.fetch_addr    = 32'h0;
    bus.squash        = 1'b0;
    bus.imemreq_rdy   = 1'b1;
    bus.imemresp_val  = 1'b0;
    bus.imemresp_data = 32'h0;
    bus.inst_rdy      = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_inst_val", 32'(bus.inst_val), 32'd0);
    check_eq("rst_drop", 32'(bus.drop_count), 32'd0);
    check_eq("rst_inst_pc", bus.inst_pc, 32'd0);
    check_eq("rst_inst_data", bus.inst_data, 32'd0);
    check_eq("rst_resp_rdy", 32'(bus.imemresp_rdy), 32'd1);
    reset = 1'b0;

    // 1: three fetches, latency 1, D always ready
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    drive(1, 32'h200, 0, 1, 1); check_eq("t1_rdy_a", 32'(bus.fetch_rdy), 32'd1);
    check_eq("t1_req_addr", bus.imemreq_addr, 32'h200); commit();
    drive(1, 32'h204, 0, 1, 1); check_eq("t1_rdy_b", 32'(bus.fetch_rdy), 32'd1); commit();
    drive(1, 32'h208, 0, 1, 1); check_eq("t1_rdy_c", 32'(bus.fetch_rdy), 32'd0);
    check_eq("t1_req_val_c", 32'(bus.imemreq_val), 32'd0);
    check_eq("t1_val_c", 32'(bus.inst_val), 32'd1); commit();
    drive(1, 32'h208, 0, 1, 1); check_eq("t1_rdy_d", 32'(bus.fetch_rdy), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 1); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t1_val_f", 32'(bus.inst_val), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 0); check_eq("t1_val_g", 32'(bus.inst_val), 32'd0); commit();

    // 2: D stalled, buffer fills and blocks further fetches
    exp_q.push_back(32'h210); exp_q.push_back(32'h214); exp_q.push_back(32'h218);
    drive(1, 32'h210, 0, 0, 1); commit();
    drive(1, 32'h214, 0, 0, 1); commit();
    drive(1, 32'h218, 0, 0, 1); check_eq("t2_rdy_c", 32'(bus.fetch_rdy), 32'd0); commit();
    drive(1, 32'h218, 0, 0, 1); check_eq("t2_rdy_d", 32'(bus.fetch_rdy), 32'd0);
    check_eq("t2_val_d", 32'(bus.inst_val), 32'd1);
    check_eq("t2_pc_d", bus.inst_pc, 32'h210); commit();
    drive(1, 32'h218, 0, 1, 1); check_eq("t2_rdy_e", 32'(bus.fetch_rdy), 32'd0); commit();
    drive(1, 32'h218, 0, 0, 1); check_eq("t2_rdy_f", 32'(bus.fetch_rdy), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 1); commit();
    drive(0, 32'h0, 0, 1, 1); commit();
    drive(0, 32'h0, 0, 1, 0); check_eq("t2_val_end", 32'(bus.inst_val), 32'd0); commit();

    // 3: squash with two in flight; redirect waits for credits
    exp_q.push_back(32'h300);
    drive(1, 32'h200, 0, 1, 0); commit();
    drive(1, 32'h204, 0, 1, 0); commit();
    drive(1, 32'h300, 1, 1, 0); check_eq("t3_rdy_sq", 32'(bus.fetch_rdy), 32'd0);
    check_eq("t3_val_sq", 32'(bus.inst_val), 32'd0); commit();
    drive(1, 32'h300, 0, 1, 1); check_eq("t3_drop2", 32'(bus.drop_count), 32'd2);
    check_eq("t3_rdy_a", 32'(bus.fetch_rdy), 32'd0); commit();
    drive(1, 32'h300, 0, 1, 1); check_eq("t3_drop1", 32'(bus.drop_count), 32'd1);
    check_eq("t3_rdy_b", 32'(bus.fetch_rdy), 32'd1);
    check_eq("t3_val_b", 32'(bus.inst_val), 32'd0); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t3_drop0", 32'(bus.drop_count), 32'd0);
    check_eq("t3_val_c", 32'(bus.inst_val), 32'd0); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t3_val_d", 32'(bus.inst_val), 32'd1); commit();

    // 4: squash in the same cycle as the oldest response
    exp_q.push_back(32'h320);
    drive(1, 32'h200, 0, 1, 0); commit();
    drive(1, 32'h204, 0, 1, 0); commit();
    drive(0, 32'h0, 1, 1, 1); check_eq("t4_val_sq", 32'(bus.inst_val), 32'd0); commit();
    drive(0, 32'h0, 0, 1, 0); check_eq("t4_drop1", 32'(bus.drop_count), 32'd1);
    check_eq("t4_val_a", 32'(bus.inst_val), 32'd0); commit();
    drive(1, 32'h320, 0, 1, 1); check_eq("t4_rdy", 32'(bus.fetch_rdy), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t4_drop0", 32'(bus.drop_count), 32'd0); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t4_val_c", 32'(bus.inst_val), 32'd1); commit();

    // 5: squash while the buffer is full and D is ready
    drive(1, 32'h400, 0, 0, 1); commit();
    drive(1, 32'h404, 0, 0, 1); commit();
    drive(0, 32'h0, 0, 0, 1); check_eq("t5_val_full", 32'(bus.inst_val), 32'd1); commit();
    drive(0, 32'h0, 1, 1, 0); check_eq("t5_val_sq", 32'(bus.inst_val), 32'd0); commit();
    drive(0, 32'h0, 0, 1, 0); check_eq("t5_val_after", 32'(bus.inst_val), 32'd0);
    check_eq("t5_rdy_after", 32'(bus.fetch_rdy), 32'd1);
    check_eq("t5_drop", 32'(bus.drop_count), 32'd0); commit();

    // 7: redirect fires in the squash cycle and is not counted as dropped
    exp_q.push_back(32'h340);
    drive(1, 32'h240, 0, 1, 0); commit();
    drive(1, 32'h340, 1, 1, 0); check_eq("t7_rdy_sq", 32'(bus.fetch_rdy), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t7_drop1", 32'(bus.drop_count), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t7_drop0", 32'(bus.drop_count), 32'd0); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t7_val", 32'(bus.inst_val), 32'd1); commit();

    // 6: asynchronous reset mid-stream
    drive(1, 32'h500, 0, 1, 0); commit();
    drive(1, 32'h504, 0, 1, 0); commit();
    drive(0, 32'h0, 1, 1, 0); commit();
    drive(0, 32'h0, 0, 1, 0); check_eq("t6_drop_pre", 32'(bus.drop_count), 32'd2);
    async_reset("t6a");
    drive(1, 32'h510, 0, 0, 0); commit();
    drive(0, 32'h0, 0, 0, 1); commit();
    drive(1, 32'h514, 0, 0, 0); commit();
    drive(0, 32'h0, 0, 0, 0); check_eq("t6_val_pre", 32'(bus.inst_val), 32'd1);
    check_eq("t6_pc_pre", bus.inst_pc, 32'h510);
    async_reset("t6b");
    exp_q.push_back(32'h200);
    drive(1, 32'h200, 0, 1, 1); check_eq("t6_rdy_post", 32'(bus.fetch_rdy), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 1); commit();
    drive(0, 32'h0, 0, 1, 1); check_eq("t6_val_post", 32'(bus.inst_val), 32'd1); commit();
    drive(0, 32'h0, 0, 1, 0); check_eq("t6_val_end", 32'(bus.inst_val), 32'd0); commit();

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
